xor_ram_tag_allocator: RTL and testbench
========================================

# xor_ram_tag_allocator

Tag allocator built around one `dual_port_xor_ram` instance, used as a DEPTH-entry busy bitmap. Port A belongs to a rotating scan pointer that hands out free tags. Port B belongs to tag release. The block also clears the bitmap after reset, because the RAM's `rst` clears only the entries currently addressed. It sits between tag-consuming requesters (for example outstanding-transaction IDs) and the toggle RAM.

## Interface
Parameters:
- `DEPTH`, 512: number of tags; any value ≥ 2, power of two not required.
- `ADDR_WIDTH`, `log2(DEPTH - 1)`: tag width (`log2` from `common.vh`).

Ports:
- `clk`: input, 1 bit. The single clock.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `ready`: output, 1 bit. Initialisation sweep complete.
- `alloc_valid`: output, 1 bit. A free tag is offered on `alloc_tag`.
- `alloc_ready`: input, 1 bit. Requester takes the offered tag.
- `alloc_tag`: output, `ADDR_WIDTH` bits. Offered tag; equals the scan pointer.
- `free_valid`: input, 1 bit. Release `free_tag` this cycle; always accepted.
- `free_tag`: input, `ADDR_WIDTH` bits. Tag being released.
- `free_err`: output, 1 bit. Registered one-cycle pulse; the previous cycle's release targeted a tag that was not busy.
- `count`: output, `ADDR_WIDTH+1` bits. Number of busy tags.
- `full`: output, 1 bit. `count == DEPTH`.
- `empty`: output, 1 bit. `count == 0`.

## Operation
- States: INIT and RUN.
- `rst` = 1 forces INIT. It sets sweep counter = 0, scan pointer = 0, `count` = 0, `free_err` = 0.
- **INIT**
  - Drives the RAM `rst` = 1, `addr_a` = `addr_b` = sweep counter, `wr_a` = `wr_b` = 0.
  - This clears both RAM halves at one address per cycle.
  - After address DEPTH-1 is cleared, goes to RUN.
  - `ready`, `alloc_valid` = 0 throughout.
  - `free_valid` is ignored: no write, no `free_err`.
- **RUN**, port A (allocation)
  - RAM `rst` = 0; `addr_a` = scan pointer.
  - `alloc_valid` = NOT `q_a`. This is combinational from the registered pointer, with no path from `alloc_ready`.
  - If `q_a` = 1 (busy), the pointer advances.
  - If `q_a` = 0 and `alloc_ready` = 1, a transfer occurs:
    - `wr_a` = 1, which toggles the entry to busy;
    - `count` increments;
    - the pointer advances.
  - If `q_a` = 0 and `alloc_ready` = 0, the pointer holds and `alloc_tag` stays stable.
  - Pointer advance: pointer+1, wrapping from DEPTH-1 to 0.
- **RUN**, port B (release)
  - `addr_b` = `free_tag`.
  - If `free_valid` = 1 and `q_b` = 1: `wr_b` = 1, which toggles the entry to free, and `count` decrements.
  - If `free_valid` = 1 and `q_b` = 0: no write; `free_err` = 1 on the next cycle.
  - If `free_valid` = 0, `free_err` is 0 on the next cycle.
- **Simultaneous transfer and release:** the two events address different entries, because one reads 0 and the other reads 1. Both take effect and `count` is unchanged.
- **Release of the currently offered tag:** that entry reads 0, so it is a release error. The offer is unaffected.
- **Full:** every entry reads 1, so the pointer spins and `alloc_valid` = 0. A release makes its tag offerable when the pointer next reaches it, within DEPTH cycles.
- **Mid-operation reset:** all in-flight tags are discarded and a full INIT sweep repeats.

## Timing
- Reset values: `ready` = 0, `alloc_valid` = 0, `alloc_tag` = 0, `free_err` = 0, `count` = 0, `full` = 0, `empty` = 1.
- INIT lasts exactly DEPTH cycles after `rst` falls.
  - `ready` rises in cycle DEPTH, counting the first cycle with `rst` low as cycle 0.
  - `alloc_valid` = 1 with tag 0 in that same cycle.
- Allocation throughput is one tag per cycle while the pointer traverses free entries.
- Worst-case wait for a free tag is DEPTH-1 cycles.
- RAM writes land at the clock edge ending the cycle. The updated bit is readable in the next cycle.
- `count`, `full` and `empty` update at the edge ending the cycle of the transfer or release.
- `free_err` appears one cycle after the offending release.

## Test plan
- **Init.** DEPTH=8. Hold `rst` for 2 cycles, then release. Expect `ready` = 0 for cycles 0–7 and `ready` = 1 in cycle 8 with `alloc_valid` = 1, `alloc_tag` = 0, `count` = 0.
- **Back-to-back allocation.** Hold `alloc_ready` = 1 for 3 cycles after `ready`. Expect tags 0, 1, 2 on consecutive cycles, then `count` = 3, and `alloc_tag` = 3 offered.
- **Release and reuse.**
  - Release tag 1, then allocate 5 more.
  - Expect tags 3–7, then a skip over busy 0, then tag 1 reissued.
  - `count` counts down from 3 to 2 after the release, then up to 7 after the five allocations; after the reissue of tag 1 it reaches 8 with `full` = 1 and `alloc_valid` = 0.
- **Double release.** Release tag 4 twice in consecutive cycles. Expect `free_err` = 0 after the first and `free_err` = 1 after the second; `count` decrements only once.
- **Simultaneous events.** `count` = 5; transfer on port A and release a busy tag in the same cycle. Expect `count` = 5 afterwards, the allocated bit set and the released bit clear.
- **Mid-run reset.** Assert `rst` with `count` = 6. Expect `count` = 0 and `ready` = 0 immediately, then 8 INIT cycles, then tag 0 offered again.

Source files
------------

// File: rtl/xor_ram_tag_allocator.sv
// Tag allocator keeping a DEPTH-entry busy bitmap in a toggle (XOR) RAM.
// Port A scans for free tags to hand out, port B releases them; a sweep clears the RAM after reset.

module dual_port_xor_ram #(
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic                  wr_a,
    output logic                  q_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic                  wr_b,
    output logic                  q_b
);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    // Each port owns one half; an entry's value is the XOR of both halves.
    logic [DEPTH-1:0] half_a;
    logic [DEPTH-1:0] half_b;
    logic             in_a;
    logic             in_b;

    assign in_a = {1'b0, addr_a} < DEPTH_W;
    assign in_b = {1'b0, addr_b} < DEPTH_W;
    assign q_a  = in_a ? (half_a[addr_a] ^ half_b[addr_a]) : 1'b0;
    assign q_b  = in_b ? (half_a[addr_b] ^ half_b[addr_b]) : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            if (in_a) half_a[addr_a] <= 1'b0;
            if (in_b) half_b[addr_b] <= 1'b0;
        end else begin
            if (wr_a && in_a) half_a[addr_a] <= ~half_a[addr_a];
            if (wr_b && in_b) half_b[addr_b] <= ~half_b[addr_b];
        end
    end
endmodule

module xor_ram_tag_allocator #(
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    output logic                  alloc_valid,
    input  logic                  alloc_ready,
    output logic [ADDR_WIDTH-1:0] alloc_tag,
    input  logic                  free_valid,
    input  logic [ADDR_WIDTH-1:0] free_tag,
    output logic                  free_err,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);
    // state | meaning
    // INIT  | clearing the RAM one address per cycle, nothing offered
    // RUN   | port A scans and allocates, port B releases
    typedef enum logic {INIT, RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST       = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] sweep;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic                  ram_rst;
    logic                  wr_a;
    logic                  wr_b;
    logic                  q_a;
    logic                  q_b;
    logic                  xfer;
    logic                  rel;
    logic                  rel_err;
    logic                  advance;

    dual_port_xor_ram #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .rst    (ram_rst),
        .addr_a (addr_a),
        .wr_a   (wr_a),
        .q_a    (q_a),
        .addr_b (addr_b),
        .wr_b   (wr_b),
        .q_b    (q_b)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        ram_rst     = 1'b0;
        addr_a      = ptr;
        addr_b      = free_tag;
        wr_a        = 1'b0;
        wr_b        = 1'b0;
        ready       = 1'b0;
        alloc_valid = 1'b0;
        xfer        = 1'b0;
        rel         = 1'b0;
        rel_err     = 1'b0;
        advance     = 1'b0;
        case (state)
            INIT: begin
                ram_rst = 1'b1;
                addr_a  = sweep;
                addr_b  = sweep;
                if (sweep == LAST) state_nxt = RUN;
            end
            RUN: begin
                ready       = 1'b1;
                alloc_valid = ~q_a;
                xfer        = ~q_a & alloc_ready;
                // A busy entry is skipped; a free one is held until taken.
                advance     = q_a | alloc_ready;
                wr_a        = xfer;
                rel         = free_valid & q_b;
                rel_err     = free_valid & ~q_b;
                wr_b        = rel;
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sweep    <= '0;
            ptr      <= '0;
            count    <= '0;
            free_err <= 1'b0;
        end else begin
            free_err <= rel_err;
            if (state == INIT) sweep <= (sweep == LAST) ? '0 : sweep + ADDR_WIDTH'(1);
            if (advance)       ptr   <= (ptr == LAST) ? '0 : ptr + ADDR_WIDTH'(1);
            if (xfer && !rel)      count <= count + (ADDR_WIDTH+1)'(1);
            else if (rel && !xfer) count <= count - (ADDR_WIDTH+1)'(1);
        end
    end

    assign alloc_tag = ptr;
    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
endmodule

// File: tb/tb_xor_ram_tag_allocator.sv
// Directed bench for xor_ram_tag_allocator (DEPTH=8); allocated tags are checked by a scoreboard monitor.

module tb_xor_ram_tag_allocator;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          ready;
    logic          alloc_valid;
    logic          alloc_ready;
    logic [AW-1:0] alloc_tag;
    logic          free_valid;
    logic [AW-1:0] free_tag;
    logic          free_err;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [AW-1:0] exp_q[$];

    always #5 clk = ~clk;

    xor_ram_tag_allocator #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .ready       (ready),
        .alloc_valid (alloc_valid),
        .alloc_ready (alloc_ready),
        .alloc_tag   (alloc_tag),
        .free_valid  (free_valid),
        .free_tag    (free_tag),
        .free_err    (free_err),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted offer must match the next expected tag.
    always @(negedge clk) begin
        if (!rst && alloc_valid && alloc_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL alloc_unexpected: got tag %0d, required no transfer", alloc_tag);
            end else begin
                chk("alloc_tag_sb", int'(alloc_tag), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; alloc_ready = 1'b0; free_valid = 1'b0; free_tag = '0;
        @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_alloc_valid", alloc_valid, 0);
        chk("rst_alloc_tag", alloc_tag, 0);
        chk("rst_free_err", free_err, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        nxt(); nxt();
        rst = 1'b0;

        // INIT cycles 0..7; releases during the sweep must be ignored
        free_valid = 1'b1; free_tag = 3'd2;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("init_ready", ready, 0);
            chk("init_free_err", free_err, 0);
            nxt();
        end
        free_valid = 1'b0;

        // cycle 8: ready, back-to-back allocation of 0,1,2
        alloc_ready = 1'b1;
        exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd2);
        @(negedge clk);
        chk("ready_rise", ready, 1);
        chk("ready_alloc_valid", alloc_valid, 1);
        chk("ready_alloc_tag", alloc_tag, 0);
        chk("ready_count", count, 0);
        chk("ready_empty", empty, 1);
        nxt(); nxt(); nxt();

        // cycle 11: release tag 1
        alloc_ready = 1'b0; free_valid = 1'b1; free_tag = 3'd1;
        @(negedge clk);
        chk("b2b_count", count, 3);
        chk("b2b_alloc_tag", alloc_tag, 3);
        chk("b2b_alloc_valid", alloc_valid, 1);
        nxt();

        // cycle 12: allocate 3..7, skip busy 0, reissue 1
        free_valid = 1'b0; alloc_ready = 1'b1;
        for (int t = 3; t < 8; t++) exp_q.push_back(AW'(t));
        exp_q.push_back(3'd1);
        @(negedge clk);
        chk("rel_count", count, 2);
        chk("rel_free_err", free_err, 0);
        repeat (5) nxt();
        @(negedge clk);
        chk("skip_count", count, 7);
        chk("skip_alloc_valid", alloc_valid, 0);
        nxt(); nxt();

        // cycle 19: full; release tag 4 twice
        alloc_ready = 1'b0; free_valid = 1'b1; free_tag = 3'd4;
        @(negedge clk);
        chk("full_count", count, 8);
        chk("full_flag", full, 1);
        chk("full_alloc_valid", alloc_valid, 0);
        nxt();
        @(negedge clk);
        chk("dbl_first_err", free_err, 0);
        chk("dbl_first_count", count, 7);
        nxt();
        free_valid = 1'b0;
        @(negedge clk);
        chk("dbl_second_err", free_err, 1);
        chk("dbl_second_count", count, 7);
        chk("refill_alloc_valid", alloc_valid, 1);
        chk("refill_alloc_tag", alloc_tag, 4);
        chk("refill_full", full, 0);
        nxt();

        // cycles 22,23: release 5 and 6 to reach count 5
        free_valid = 1'b1; free_tag = 3'd5;
        @(negedge clk);
        chk("err_clear", free_err, 0);
        nxt();
        free_tag = 3'd6;
        nxt();

        // cycle 24: simultaneous transfer of tag 4 and release of tag 7
        free_tag = 3'd7; alloc_ready = 1'b1;
        exp_q.push_back(3'd4);
        @(negedge clk);
        chk("sim_pre_count", count, 5);
        chk("sim_pre_tag", alloc_tag, 4);
        nxt();
        alloc_ready = 1'b0; free_tag = 3'd7;
        @(negedge clk);
        chk("sim_post_count", count, 5);
        chk("sim_post_err", free_err, 0);
        nxt();
        free_tag = 3'd4;
        @(negedge clk);
        chk("sim_released_clear", free_err, 1);
        chk("sim_err_count", count, 5);
        nxt();

        // cycle 27: allocate 5 and 6
        free_valid = 1'b0; alloc_ready = 1'b1;
        exp_q.push_back(3'd5); exp_q.push_back(3'd6);
        @(negedge clk);
        chk("sim_alloc_bit_set", free_err, 0);
        chk("sim_alloc_count", count, 4);
        nxt(); nxt();
        alloc_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_count", count, 6);
        chk("pre_rst_tag", alloc_tag, 7);
        chk("pre_rst_valid", alloc_valid, 1);
        nxt();

        // mid-run reset
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_count", count, 0);
        chk("mrst_ready", ready, 0);
        chk("mrst_alloc_valid", alloc_valid, 0);
        chk("mrst_empty", empty, 1);
        nxt();
        for (int i = 1; i < DEPTH; i++) begin
            @(negedge clk);
            chk("mrst_init_ready", ready, 0);
            nxt();
        end

        // every entry must be free again after the sweep
        alloc_ready = 1'b1;
        for (int t = 0; t < DEPTH; t++) exp_q.push_back(AW'(t));
        @(negedge clk);
        chk("mrst_ready_rise", ready, 1);
        chk("mrst_alloc_tag", alloc_tag, 0);
        chk("mrst_valid", alloc_valid, 1);
        repeat (DEPTH) nxt();
        alloc_ready = 1'b0;
        @(negedge clk);
        chk("final_count", count, 8);
        chk("final_full", full, 1);
        chk("final_alloc_valid", alloc_valid, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
